// File: rtl/cim_pkg.sv
// Constants and FSM encoding shared by the CIM control unit and the TDC readout stage.
package cim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_HOLD,
    S_EMIT
  } state_t;

  localparam int T_WINDOW_DEF = 42;
  localparam int LOOP_PERIOD  = 54;
  localparam int READ_LOOPS   = 10;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, cleared by an async active-high clear.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) chain <= '0;
    else     chain <= STAGES'({chain, d});
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/tdc_readout.sv
// Time-domain readout: times each read loop to the comparator crossing, accumulates a burst,
// and hands one result word downstream over valid/ready.
module tdc_readout
  import cim_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int ACC_W       = 10,
  parameter int T_WINDOW    = T_WINDOW_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             compute_sig,
  input  logic             input_ctrl,
  input  logic             pre_charge_ctrl,
  input  logic             sense_cmp,
  output logic [ACC_W-1:0] result_acc,
  output logic [3:0]       result_loops,
  output logic [3:0]       result_timeouts,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun,
  output logic             busy
);

  localparam logic [CNT_W-1:0] T_END = CNT_W'(T_WINDOW + SYNC_STAGES);
  localparam logic [CNT_W-1:0] T_LAT = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] T_TO  = CNT_W'(T_WINDOW);

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] a,
                                               input logic [CNT_W-1:0] v);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(ACC_W + 1 - CNT_W){1'b0}}, v};
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  state_t           state;
  logic             cmp_s;
  logic             input_ctrl_p1;
  logic             compute_sig_p1;
  logic             ic_rise;
  logic             cs_fall;
  logic             tout_end;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] meas_val;
  logic [ACC_W-1:0] acc;
  logic [3:0]       loops;
  logic [3:0]       timeouts;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .clr (rst),
    .d   (sense_cmp),
    .q   (cmp_s)
  );

  assign ic_rise = input_ctrl & ~input_ctrl_p1;
  assign cs_fall = ~compute_sig & compute_sig_p1;
  assign busy    = (state != S_IDLE);

  // timer counts ticks elapsed since E, so subtracting the synchronizer depth yields k
  always_comb begin
    tout_end = (timer == T_END) || !pre_charge_ctrl;
    if (cmp_s) meas_val = (timer > T_LAT) ? timer - T_LAT : '0;
    else       meas_val = T_TO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      input_ctrl_p1   <= 1'b0;
      compute_sig_p1  <= 1'b0;
      timer           <= '0;
      acc             <= '0;
      loops           <= '0;
      timeouts        <= '0;
      result_acc      <= '0;
      result_loops    <= '0;
      result_timeouts <= '0;
      result_valid    <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      input_ctrl_p1  <= input_ctrl;
      compute_sig_p1 <= compute_sig;
      overrun        <= 1'b0;
      if (result_valid && result_ready) result_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (compute_sig) begin
            acc      <= '0;
            loops    <= '0;
            timeouts <= '0;
            state    <= S_ARM;
          end
        end
        S_ARM, S_HOLD: begin
          if (cs_fall) begin
            state <= (loops != 4'd0) ? S_EMIT : S_IDLE;
          end else if (ic_rise) begin
            timer <= CNT_W'(1);
            state <= S_MEAS;
          end
        end
        S_MEAS: begin
          // burst end aborts the loop before any end condition is honoured
          if (cs_fall) begin
            state <= (loops != 4'd0) ? S_EMIT : S_IDLE;
          end else if (cmp_s || tout_end) begin
            acc   <= sat_acc(acc, meas_val);
            loops <= sat_inc4(loops);
            if (!cmp_s) timeouts <= sat_inc4(timeouts);
            state <= S_HOLD;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        S_EMIT: begin
          if (!result_valid || result_ready) begin
            result_acc      <= acc;
            result_loops    <= loops;
            result_timeouts <= timeouts;
            result_valid    <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_readout.sv
// Randomised and directed bench for tdc_readout with a tick-arithmetic burst model.
module tb_tdc_readout;

  localparam int TW   = 42;
  localparam int LAT  = 2;
  localparam int TEND = TW + LAT;
  localparam int AMAX = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       compute_sig = 1'b0;
  logic       input_ctrl = 1'b0;
  logic       pre_charge_ctrl = 1'b1;
  logic       sense_cmp = 1'b0;
  logic       result_ready = 1'b0;
  logic [9:0] result_acc;
  logic [3:0] result_loops;
  logic [3:0] result_timeouts;
  logic       result_valid;
  logic       overrun;
  logic       busy;

  tdc_readout dut (
    .clk             (clk),
    .rst             (rst),
    .compute_sig     (compute_sig),
    .input_ctrl      (input_ctrl),
    .pre_charge_ctrl (pre_charge_ctrl),
    .sense_cmp       (sense_cmp),
    .result_acc      (result_acc),
    .result_loops    (result_loops),
    .result_timeouts (result_timeouts),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .overrun         (overrun),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int ready_mode = 1;
  int kv[32];
  int pv[32];

  // totals of the burst being driven, from loop timing arithmetic
  int b_acc = 0, b_loops = 0, b_touts = 0;

  // expected outputs
  logic m_valid = 1'b0, m_ovr = 1'b0, m_active = 1'b0, m_emit = 1'b0, m_cs_prev = 1'b0;
  int   m_acc = 0, m_loops = 0, m_touts = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_active = 1'b0; m_emit = 1'b0; m_cs_prev = 1'b0;
      m_acc = 0; m_loops = 0; m_touts = 0;
    end else begin
      logic vb;
      vb = m_valid;
      m_ovr = 1'b0;
      if (vb && result_ready) m_valid = 1'b0;
      if (m_emit) begin
        if (!vb || result_ready) begin
          m_valid = 1'b1; m_acc = b_acc; m_loops = b_loops; m_touts = b_touts;
        end else begin
          m_ovr = 1'b1;
        end
        m_emit = 1'b0;
        m_active = 1'b0;
      end else if (!m_active) begin
        if (compute_sig) m_active = 1'b1;
      end else if (m_cs_prev && !compute_sig) begin
        if (b_loops > 0) m_emit = 1'b1;
        else m_active = 1'b0;
      end
      m_cs_prev = compute_sig;
    end
  end

  int vcyc = 0, ovr_cnt = 0;
  int last_acc = -1, last_loops = -1, last_touts = -1;

  always @(negedge clk) begin
    compared++;
    if (result_valid !== m_valid || result_acc !== 10'(m_acc) ||
        result_loops !== 4'(m_loops) || result_timeouts !== 4'(m_touts)) begin
      mismatched++;
      $display("FAIL result t=%0t got v=%0b acc=%0d loops=%0d to=%0d want v=%0b acc=%0d loops=%0d to=%0d",
               $time, result_valid, result_acc, result_loops, result_timeouts,
               m_valid, m_acc, m_loops, m_touts);
    end
    compared++;
    if (overrun !== m_ovr) begin
      mismatched++;
      $display("FAIL overrun t=%0t got %0b want %0b", $time, overrun, m_ovr);
    end
    compared++;
    if (busy !== m_active) begin
      mismatched++;
      $display("FAIL busy t=%0t got %0b want %0b", $time, busy, m_active);
    end
    if (result_valid === 1'b1) vcyc++;
    if (overrun === 1'b1) ovr_cnt++;
    if (result_valid === 1'b1 && result_ready === 1'b1) begin
      last_acc = int'(result_acc); last_loops = int'(result_loops); last_touts = int'(result_timeouts);
    end
  end

  task automatic check(input string name, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    case (ready_mode)
      0:       result_ready = 1'b0;
      1:       result_ready = 1'b1;
      default: result_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    #2;
  endtask

  // One 54-tick loop: ticks -4..-1 lead-in, E at tick 0, input_ctrl high ticks 0..29.
  // k: first tick sense_cmp is high (<0: already high), p: first tick pre_charge low (0: never),
  // a: tick at which compute_sig falls.
  task automatic run_loop(input int k, input int p, input int a, output bit aborted);
    int tc, tp, te, v;
    bit to;
    tc = (k + LAT < 1) ? 1 : k + LAT;
    tp = (p > 0) ? p : 1000;
    if (tc <= TEND && tc <= tp) begin
      te = tc; v = (tc > LAT) ? tc - LAT : 0; to = 1'b0;
    end else begin
      te = (tp < TEND) ? tp : TEND; v = TW; to = 1'b1;
    end
    aborted = (a <= te);
    if (!aborted) begin
      b_acc   = (b_acc + v > AMAX) ? AMAX : b_acc + v;
      b_loops = (b_loops < 15) ? b_loops + 1 : 15;
      if (to) b_touts = (b_touts < 15) ? b_touts + 1 : 15;
    end
    for (int t = -4; t < 50; t++) begin
      input_ctrl      = (t >= 0 && t < 30);
      sense_cmp       = (t < 46) && (k < 0 || t >= k);
      pre_charge_ctrl = !(p > 0 && t >= p && t < 46);
      if (t >= a) compute_sig = 1'b0;
      step();
    end
  endtask

  task automatic burst(input int n, input int abort_loop, input int abort_tick);
    bit ab;
    b_acc = 0; b_loops = 0; b_touts = 0;
    compute_sig = 1'b1;
    repeat (3) step();
    for (int i = 0; i < n; i++) begin
      run_loop(kv[i], pv[i], (i == abort_loop) ? abort_tick : 1000, ab);
      if (ab) break;
    end
    compute_sig = 1'b0;
    repeat (6) step();
  endtask

  task automatic fill(input int n, input int k, input int p);
    for (int i = 0; i < n; i++) begin
      kv[i] = k; pv[i] = p;
    end
  endtask

  task automatic check_last(input string name, input int acc, input int loops, input int touts);
    check({name, "_acc"}, last_acc, acc);
    check({name, "_loops"}, last_loops, loops);
    check({name, "_timeouts"}, last_touts, touts);
  endtask

  initial begin
    int v0, o0, n, al, at;
    @(posedge clk); #2;
    step();
    check("rst_valid", int'(result_valid), 0);
    check("rst_acc", int'(result_acc), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    step();

    // crossing at E+10 every loop
    ready_mode = 1; fill(10, 10, 0); v0 = vcyc;
    burst(10, -1, 0);
    check_last("k10", 100, 10, 0);
    check("k10_valid_cycles", vcyc - v0, 1);

    // no crossing: every loop times out
    fill(10, 47, 0);
    burst(10, -1, 0);
    check_last("never", 420, 10, 10);

    // comparator already high at E, then crossing just past the window
    fill(10, -1, 0);
    burst(10, -1, 0);
    check_last("pre_high", 0, 10, 0);
    fill(10, 43, 0);
    burst(10, -1, 0);
    check_last("late", 420, 10, 10);

    // mixed crossings, fifth loop aborted mid-measurement
    kv[0] = 0; kv[1] = 5; kv[2] = 41; kv[3] = 47; kv[4] = 20;
    fill(0, 0, 0); pv[0] = 0; pv[1] = 0; pv[2] = 0; pv[3] = 0; pv[4] = 0;
    burst(5, 4, 10);
    check_last("mixed", 88, 4, 1);

    // crossing ties with window end and with pre-charge drop; pre-charge forced end
    kv[0] = 42; pv[0] = 0; kv[1] = 42; pv[1] = 44; kv[2] = 47; pv[2] = 20;
    burst(3, -1, 0);
    check_last("ties", 126, 3, 1);

    // saturation of accumulator and counters
    fill(25, 47, 0);
    burst(25, -1, 0);
    check_last("sat", 1023, 15, 15);

    // backpressure across two bursts
    ready_mode = 0; o0 = ovr_cnt;
    fill(3, 10, 0); burst(3, -1, 0);
    fill(2, 47, 0); burst(2, -1, 0);
    check("bp_overrun_pulses", ovr_cnt - o0, 1);
    check("bp_held_valid", int'(result_valid), 1);
    check("bp_held_acc", int'(result_acc), 30);
    ready_mode = 1;
    repeat (2) step();
    check("bp_valid_drop", int'(result_valid), 0);
    check_last("bp_accept", 30, 3, 0);

    // reset during loop 6
    b_acc = 0; b_loops = 0; b_touts = 0;
    compute_sig = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      bit ab;
      run_loop(10, 0, 1000, ab);
    end
    for (int t = -4; t < 8; t++) begin
      input_ctrl = (t >= 0); sense_cmp = 1'b0; pre_charge_ctrl = 1'b1;
      step();
    end
    v0 = vcyc;
    rst = 1'b1; compute_sig = 1'b0; input_ctrl = 1'b0;
    #1;
    check("mid_rst_acc", int'(result_acc), 0);
    check("mid_rst_loops", int'(result_loops), 0);
    check("mid_rst_busy", int'(busy), 0);
    step(); step();
    rst = 1'b0;
    repeat (60) step();
    check("post_rst_no_result", vcyc - v0, 0);
    fill(4, 7, 0);
    burst(4, -1, 0);
    check_last("post_rst", 28, 4, 0);

    // randomised bursts with random backpressure and aborts
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        kv[i] = int'($urandom_range(0, 48)) - 1;
        pv[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : 0;
      end
      al = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      at = int'($urandom_range(0, 53)) - 4;
      burst(n, al, at);
    end
    ready_mode = 1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
